// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the FSM state types of the demultiplexer.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_ERR} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_FWD, WR_RESP, WR_ERR} wr_state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Slave select decode: the top address bits name the slave; indices past NUM_SLAVES miss.
module axi_lite_addr_decode #(
  parameter int SEL_BITS   = 2,
  parameter int NUM_SLAVES = 4
) (
  input  logic [SEL_BITS-1:0] addr_hi,
  output logic [SEL_BITS-1:0] idx,
  output logic                hit
);

  localparam logic [SEL_BITS:0] NS = (SEL_BITS+1)'(NUM_SLAVES);

  assign idx = addr_hi;
  assign hit = {1'b0, addr_hi} < NS;

endmodule

// File: rtl/axi_lite_demux.sv
// 1-to-N AXI4-Lite demultiplexer: independent read and write paths, one outstanding
// transaction each, routed by the top address bits, DECERR answered locally.
module axi_lite_demux
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 2,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [ADDR_WIDTH-1:0]            s_araddr,
  input  logic                             s_arvalid,
  output logic                             s_arready,
  output logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [1:0]                       s_rresp,
  output logic                             s_rvalid,
  input  logic                             s_rready,
  input  logic [ADDR_WIDTH-1:0]            s_awaddr,
  input  logic                             s_awvalid,
  output logic                             s_awready,
  input  logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [STRB_WIDTH-1:0]            s_wstrb,
  input  logic                             s_wvalid,
  output logic                             s_wready,
  output logic [1:0]                       s_bresp,
  output logic                             s_bvalid,
  input  logic                             s_bready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_araddr,
  output logic [NUM_SLAVES-1:0]            m_arvalid,
  input  logic [NUM_SLAVES-1:0]            m_arready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_rdata,
  input  logic [NUM_SLAVES*2-1:0]          m_rresp,
  input  logic [NUM_SLAVES-1:0]            m_rvalid,
  output logic [NUM_SLAVES-1:0]            m_rready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_awaddr,
  output logic [NUM_SLAVES-1:0]            m_awvalid,
  input  logic [NUM_SLAVES-1:0]            m_awready,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_SLAVES*STRB_WIDTH-1:0] m_wstrb,
  output logic [NUM_SLAVES-1:0]            m_wvalid,
  input  logic [NUM_SLAVES-1:0]            m_wready,
  input  logic [NUM_SLAVES*2-1:0]          m_bresp,
  input  logic [NUM_SLAVES-1:0]            m_bvalid,
  output logic [NUM_SLAVES-1:0]            m_bready
);

  rd_state_t             rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [SEL_BITS-1:0]   ar_idx_q, ar_idx_d;
  logic [SEL_BITS-1:0]   ar_dec_idx;
  logic                  ar_dec_hit;

  wr_state_t             wr_q, wr_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  aw_hit_q, aw_hit_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [SEL_BITS-1:0]   aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [SEL_BITS-1:0]   aw_dec_idx;
  logic                  aw_dec_hit;

  axi_lite_addr_decode #(.SEL_BITS(SEL_BITS), .NUM_SLAVES(NUM_SLAVES)) u_ar_dec (
    .addr_hi(s_araddr[ADDR_WIDTH-1 -: SEL_BITS]), .idx(ar_dec_idx), .hit(ar_dec_hit)
  );

  axi_lite_addr_decode #(.SEL_BITS(SEL_BITS), .NUM_SLAVES(NUM_SLAVES)) u_aw_dec (
    .addr_hi(s_awaddr[ADDR_WIDTH-1 -: SEL_BITS]), .idx(aw_dec_idx), .hit(aw_dec_hit)
  );

  // Read path. All pass-through muxing keys off the latched index.
  always_comb begin
    rd_d      = rd_q;
    ar_addr_d = ar_addr_q;
    ar_idx_d  = ar_idx_q;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = RESP_OKAY;
    m_arvalid = '0;
    m_araddr  = '0;
    m_rready  = '0;
    case (rd_q)
      RD_IDLE: begin
        s_arready = !areset;
        if (s_arvalid && s_arready) begin
          ar_addr_d = s_araddr;
          ar_idx_d  = ar_dec_idx;
          rd_d      = ar_dec_hit ? RD_ADDR : RD_ERR;
        end
      end
      RD_ADDR: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (ar_idx_q == SEL_BITS'(i)) begin
            m_arvalid[i]                         = 1'b1;
            m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] = ar_addr_q;
            if (m_arready[i]) rd_d = RD_DATA;
          end
        end
      end
      RD_DATA: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (ar_idx_q == SEL_BITS'(i)) begin
            m_rready[i] = s_rready;
            s_rvalid    = m_rvalid[i];
            s_rdata     = m_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            s_rresp     = m_rresp[i*2 +: 2];
            if (m_rvalid[i] && s_rready) rd_d = RD_IDLE;
          end
        end
      end
      RD_ERR: begin
        s_rvalid = 1'b1;
        s_rresp  = RESP_DECERR;
        if (s_rready) rd_d = RD_IDLE;
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  // Write path. AW and W are collected independently in IDLE, then forwarded together.
  always_comb begin
    wr_d      = wr_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_hit_d  = aw_hit_q;
    aw_addr_d = aw_addr_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    m_awvalid = '0;
    m_awaddr  = '0;
    m_wvalid  = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_bready  = '0;
    case (wr_q)
      WR_IDLE: begin
        s_awready = !areset && !aw_held_q;
        s_wready  = !areset && !w_held_q;
        if (s_awvalid && s_awready) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_awaddr;
          aw_idx_d  = aw_dec_idx;
          aw_hit_d  = aw_dec_hit;
        end
        if (s_wvalid && s_wready) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          wr_d      = aw_hit_d ? WR_FWD : WR_ERR;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_FWD: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (aw_idx_q == SEL_BITS'(i)) begin
            m_awvalid[i] = !aw_done_q;
            m_wvalid[i]  = !w_done_q;
            if (!aw_done_q) m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH] = aw_addr_q;
            if (!w_done_q) begin
              m_wdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
              m_wstrb[i*STRB_WIDTH +: STRB_WIDTH] = wstrb_q;
            end
            if (!aw_done_q && m_awready[i]) aw_done_d = 1'b1;
            if (!w_done_q && m_wready[i])   w_done_d  = 1'b1;
          end
        end
        if (aw_done_d && w_done_d) wr_d = WR_RESP;
      end
      WR_RESP: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (aw_idx_q == SEL_BITS'(i)) begin
            m_bready[i] = s_bready;
            s_bvalid    = m_bvalid[i];
            s_bresp     = m_bresp[i*2 +: 2];
            if (m_bvalid[i] && s_bready) wr_d = WR_IDLE;
          end
        end
      end
      WR_ERR: begin
        s_bvalid = 1'b1;
        s_bresp  = RESP_DECERR;
        if (s_bready) wr_d = WR_IDLE;
      end
      default: wr_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_q      <= RD_IDLE;
      ar_addr_q <= '0;
      ar_idx_q  <= '0;
      wr_q      <= WR_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_hit_q  <= 1'b0;
      aw_addr_q <= '0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      rd_q      <= rd_d;
      ar_addr_q <= ar_addr_d;
      ar_idx_q  <= ar_idx_d;
      wr_q      <= wr_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      aw_hit_q  <= aw_hit_d;
      aw_addr_q <= aw_addr_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_demux.sv
// Scoreboard bench: drivers push expected results, slave models and an upstream monitor pop and compare.
module tb_axi_lite_demux;

  localparam int AW = 12, DW = 32, SW = 4, NS = 3, SB = 2, TMO = 300;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [1:0] s_rresp, s_bresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [SW-1:0] s_wstrb;
  logic [NS*AW-1:0] m_araddr, m_awaddr;
  logic [NS-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic [NS-1:0] m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NS*DW-1:0] m_rdata, m_wdata;
  logic [NS*2-1:0] m_rresp, m_bresp;
  logic [NS*SW-1:0] m_wstrb;

  always #5 aclk = ~aclk;

  axi_lite_demux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_BITS(SB)) dut (
    .aclk(aclk), .areset(areset),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  typedef struct {logic [SB-1:0] idx; logic [AW-1:0] addr;} a_exp_t;
  typedef struct {logic [SB-1:0] idx; logic [DW-1:0] data; logic [SW-1:0] strb;} w_exp_t;
  typedef struct {logic [DW-1:0] data; logic [1:0] resp;} r_exp_t;

  a_exp_t ar_q[$], aw_q[$];
  w_exp_t w_q[$];
  r_exp_t r_q[$];
  logic [1:0] b_q[$];

  int checks = 0, errors = 0;
  logic [DW-1:0] smem [NS][256];

  // Slave model knobs
  int ar_stall[NS];
  bit hold_r = 1'b0, hold_wr = 1'b0;
  bit r_pend[NS];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake t=%0t", nm, $time);
  endtask

  function automatic logic [1:0] rresp_of(input logic [AW-1:0] a);
    return (int'(a[9:2]) % 7 == 3) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [1:0] bresp_of(input logic [AW-1:0] a);
    return (int'(a[9:2]) % 5 == 1) ? 2'b10 : 2'b00;
  endfunction

  // Reference: slave index is the top two address bits; index 3 is unmapped with NS=3.
  task automatic do_read(input logic [AW-1:0] a);
    int idx = int'(a[AW-1 -: SB]);
    int n = 0;
    r_exp_t e;
    if (idx < NS) begin
      e.data = smem[idx][a[9:2]];
      e.resp = rresp_of(a);
      ar_q.push_back('{SB'(idx), a});
    end else begin
      e.data = '0;
      e.resp = 2'b11;
    end
    r_q.push_back(e);
    @(negedge aclk);
    s_araddr = a; s_arvalid = 1'b1;
    #1;
    while (!s_arready) begin
      @(negedge aclk); #1; n++;
      if (n > TMO) begin tmo_fail("ar_handshake"); break; end
    end
    @(negedge aclk);
    s_arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [AW-1:0] a, input int dly);
    int n = 0;
    repeat (dly) @(negedge aclk);
    @(negedge aclk);
    s_awaddr = a; s_awvalid = 1'b1;
    #1;
    while (!s_awready) begin
      @(negedge aclk); #1; n++;
      if (n > TMO) begin tmo_fail("aw_handshake"); break; end
    end
    @(negedge aclk);
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input int dly);
    int n = 0;
    repeat (dly) @(negedge aclk);
    @(negedge aclk);
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    #1;
    while (!s_wready) begin
      @(negedge aclk); #1; n++;
      if (n > TMO) begin tmo_fail("w_handshake"); break; end
    end
    @(negedge aclk);
    s_wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input int aw_dly, input int w_dly);
    int idx = int'(a[AW-1 -: SB]);
    if (idx < NS) begin
      aw_q.push_back('{SB'(idx), a});
      w_q.push_back('{SB'(idx), d, s});
      b_q.push_back(bresp_of(a));
    end else begin
      b_q.push_back(2'b11);
    end
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
  endtask

  task automatic drain();
    int n = 0;
    while (r_q.size() != 0 || b_q.size() != 0 || ar_q.size() != 0 || aw_q.size() != 0 || w_q.size() != 0) begin
      @(negedge aclk); n++;
      if (n > TMO) begin tmo_fail("drain"); break; end
    end
  endtask

  // Upstream monitor: randomises r/b ready and checks responses and ready behaviour.
  bit rd_busy = 1'b0, aw_held = 1'b0, w_held = 1'b0;
  always begin
    r_exp_t e;
    logic [1:0] eb;
    @(negedge aclk);
    s_rready = ($urandom % 3) != 0;
    s_bready = ($urandom % 3) != 0;
    #1;
    if (areset) begin
      rd_busy = 1'b0; aw_held = 1'b0; w_held = 1'b0;
    end else begin
      chk("s_arready", s_arready, !rd_busy);
      chk("s_awready", s_awready, !aw_held);
      chk("s_wready", s_wready, !w_held);
      if (s_arvalid && s_arready) rd_busy = 1'b1;
      if (s_awvalid && s_awready) aw_held = 1'b1;
      if (s_wvalid && s_wready) w_held = 1'b1;
      if (s_rvalid && s_rready) begin
        if (r_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          e = r_q.pop_front();
          chk("rdata", s_rdata, e.data);
          chk("rresp", s_rresp, e.resp);
        end
        rd_busy = 1'b0;
      end
      if (s_bvalid && s_bready) begin
        if (b_q.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          eb = b_q.pop_front();
          chk("bresp", s_bresp, eb);
        end
        aw_held = 1'b0; w_held = 1'b0;
      end
    end
  end

  // Downstream slave models plus routing, isolation and stability checks.
  logic [AW-1:0] r_addr[NS], b_addr[NS], prev_araddr[NS];
  int r_dly[NS], b_dly[NS];
  bit aw_got[NS], w_got[NS], b_pend[NS], prev_stall[NS];
  always begin
    bit ok;
    a_exp_t ea;
    w_exp_t ew;
    @(negedge aclk);
    for (int i = 0; i < NS; i++) begin
      m_arready[i] = (ar_stall[i] > 0) ? 1'b0 : (($urandom % 4) != 0);
      m_rvalid[i]  = r_pend[i] && r_dly[i] == 0 && !hold_r;
      m_rdata[i*DW +: DW] = m_rvalid[i] ? smem[i][r_addr[i][9:2]] : DW'($urandom);
      m_rresp[i*2 +: 2]   = m_rvalid[i] ? rresp_of(r_addr[i]) : 2'($urandom);
      m_awready[i] = !hold_wr && !aw_got[i] && (($urandom % 3) != 0);
      m_wready[i]  = !hold_wr && !w_got[i] && (($urandom % 3) != 0);
      m_bvalid[i]  = b_pend[i] && b_dly[i] == 0;
      m_bresp[i*2 +: 2] = m_bvalid[i] ? bresp_of(b_addr[i]) : 2'($urandom);
    end
    #1;
    if (areset) begin
      for (int i = 0; i < NS; i++) begin
        r_pend[i] = 0; aw_got[i] = 0; w_got[i] = 0; b_pend[i] = 0; prev_stall[i] = 0;
      end
    end else begin
      ok = ($countones(m_rready) <= 1) && ($countones(m_bready) <= 1);
      for (int j = 0; j < NS; j++) begin
        if (m_arvalid[j]) ok &= (ar_q.size() != 0) && (int'(ar_q[0].idx) == j);
        else ok &= (m_araddr[j*AW +: AW] == '0);
        if (m_awvalid[j]) ok &= (aw_q.size() != 0) && (int'(aw_q[0].idx) == j);
        else ok &= (m_awaddr[j*AW +: AW] == '0);
        if (m_wvalid[j]) ok &= (w_q.size() != 0) && (int'(w_q[0].idx) == j);
        else ok &= (m_wdata[j*DW +: DW] == '0) && (m_wstrb[j*SW +: SW] == '0);
      end
      chk("slot_iso", ok, 1);
      for (int i = 0; i < NS; i++) begin
        if (prev_stall[i]) chk("ar_stable", {m_arvalid[i], m_araddr[i*AW +: AW]}, {1'b1, prev_araddr[i]});
        prev_stall[i]  = m_arvalid[i] && !m_arready[i];
        prev_araddr[i] = m_araddr[i*AW +: AW];
        if (m_arvalid[i] && ar_stall[i] > 0) ar_stall[i]--;
        if (m_arvalid[i] && m_arready[i]) begin
          if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
          else begin
            ea = ar_q.pop_front();
            chk("ar_route", {SB'(i), m_araddr[i*AW +: AW]}, {ea.idx, ea.addr});
          end
          r_pend[i] = 1; r_addr[i] = m_araddr[i*AW +: AW]; r_dly[i] = int'($urandom % 3);
        end else if (m_rvalid[i] && m_rready[i]) r_pend[i] = 0;
        else if (r_pend[i] && r_dly[i] > 0) r_dly[i]--;
        if (m_awvalid[i] && m_awready[i]) begin
          if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            ea = aw_q.pop_front();
            chk("aw_route", {SB'(i), m_awaddr[i*AW +: AW]}, {ea.idx, ea.addr});
          end
          aw_got[i] = 1; b_addr[i] = m_awaddr[i*AW +: AW];
        end
        if (m_wvalid[i] && m_wready[i]) begin
          if (w_q.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            ew = w_q.pop_front();
            chk("w_route", {SB'(i), m_wstrb[i*SW +: SW], m_wdata[i*DW +: DW]}, {ew.idx, ew.strb, ew.data});
          end
          w_got[i] = 1;
        end
        if (m_bvalid[i] && m_bready[i]) b_pend[i] = 0;
        else if (b_pend[i] && b_dly[i] > 0) b_dly[i]--;
        if (aw_got[i] && w_got[i] && !b_pend[i]) begin
          b_pend[i] = 1; b_dly[i] = int'($urandom % 3); aw_got[i] = 0; w_got[i] = 0;
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s"}, {s_arready, s_rvalid, s_rdata, s_rresp, s_awready, s_wready, s_bvalid, s_bresp}, 0);
    chk({tag, "_m_a"}, {m_arvalid, m_araddr, m_rready, m_awvalid, m_awaddr}, 0);
    chk({tag, "_m_w"}, {m_wvalid, m_wdata, m_wstrb, m_bready}, 0);
  endtask

  initial begin
    int n;
    s_araddr = '0; s_arvalid = 0; s_awaddr = '0; s_awvalid = 0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    for (int i = 0; i < NS; i++) begin
      ar_stall[i] = 0;
      for (int k = 0; k < 256; k++) smem[i][k] = DW'($urandom);
    end
    smem[1][1] = 32'hDEADBEEF;

    repeat (3) @(negedge aclk);
    #1 chk_all_zero("reset");
    @(negedge aclk);
    areset = 1'b0;
    #1 chk("post_reset_rdy", {s_arready, s_awready, s_wready}, 3'b111);

    do_read(12'h404);
    do_write(12'h808, 32'h12345678, 4'hF, 1, 0);
    do_read(12'hC00);
    do_write(12'hC00, 32'hCAFEF00D, 4'h3, 0, 0);
    drain();

    ar_stall[0] = 5;
    do_read(12'h010);
    drain();
    chk("stall_consumed", ar_stall[0], 0);

    fork
      do_read(12'h4A0);
      do_write(12'h4A4, 32'hA5A55A5A, 4'h9, 0, 2);
    join
    drain();

    for (int k = 0; k < 80; k++) begin
      fork
        do_read(AW'($urandom));
        do_write(AW'($urandom), DW'($urandom), SW'($urandom), int'($urandom % 3), int'($urandom % 3));
      join
    end
    drain();

    // Abort a read parked in RD_DATA and a write parked in WR_FWD.
    hold_r = 1'b1; hold_wr = 1'b1;
    fork
      do_read(12'h444);
      do_write(12'h888, 32'h0BADC0DE, 4'hF, 0, 0);
    join
    n = 0;
    while (!r_pend[1]) begin
      @(negedge aclk); n++;
      if (n > TMO) begin tmo_fail("reach_rd_data"); break; end
    end
    @(negedge aclk);
    #1 chk("fwd_before_reset", {m_awvalid[2], m_wvalid[2]}, 2'b11);
    @(negedge aclk);
    areset = 1'b1;
    ar_q.delete(); aw_q.delete(); w_q.delete(); r_q.delete(); b_q.delete();
    @(negedge aclk);
    #1 chk_all_zero("abort");
    @(negedge aclk);
    areset = 1'b0; hold_r = 1'b0; hold_wr = 1'b0;
    do_read(12'h408);
    do_write(12'h00C, 32'h600DF00D, 4'hC, 0, 1);
    drain();

    repeat (5) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
